// File: rtl/rr_switch_allocator.sv
// rr_switch_allocator: separable round-robin switch allocator with a per-input
// starvation watchdog. Define SA_PACKET_LOCK_EN for wormhole per-output packet locks.
module rr_switch_allocator #(
    parameter  int N              = 5,
    parameter  int DEADLOCK_LIMIT = 100,
    localparam int SEL_W          = $clog2(N + 1),
    localparam int CNT_W          = $clog2(DEADLOCK_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     outputPortRequest [0:N-1],
    input  logic [N-1:0]     requestTail,
    input  logic [N-1:0]     holdPorts,
    output logic [SEL_W-1:0] sel [0:N-1],
    output logic [N-1:0]     readRequest,
    output logic [N-1:0]     writeRequest_Out,
    output logic [N-1:0]     drop
);

    localparam int IDX_W = $clog2(N);

    function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] ptr_q [0:N-1];
    logic [IDX_W-1:0] ptr_d [0:N-1];
    logic [CNT_W-1:0] wcnt_q [0:N-1];
    logic [CNT_W-1:0] wcnt_d [0:N-1];

    logic [N-1:0]     hasReq;
    logic [N-1:0]     allowed [0:N-1];
    logic [N-1:0]     reqM [0:N-1];
    logic [N-1:0]     ptrHold;
    logic [N-1:0]     grantValid;
    logic [IDX_W-1:0] grantIdx [0:N-1];
    logic [N-1:0]     inputGranted;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            hasReq[i] = |outputPortRequest[i];
            drop[i]   = hasReq[i] && (wcnt_q[i] == CNT_W'(DEADLOCK_LIMIT));
        end
    end

`ifdef SA_PACKET_LOCK_EN
    logic [N-1:0]     lockValid_q, lockValid_d;
    logic [IDX_W-1:0] lockOwner_q [0:N-1];
    logic [IDX_W-1:0] lockOwner_d [0:N-1];

    // A locked output only admits its owner and keeps its pointer where it was.
    always_comb begin
        ptrHold = '0;
        for (int o = 0; o < N; o++) begin
            ptrHold[o] = lockValid_q[o];
            for (int i = 0; i < N; i++)
                allowed[o][i] = !lockValid_q[o] || (lockOwner_q[o] == IDX_W'(i));
        end
    end

    always_comb begin
        lockValid_d = lockValid_q;
        for (int o = 0; o < N; o++) begin
            lockOwner_d[o] = lockOwner_q[o];
            if (lockValid_q[o]) begin
                if (drop[lockOwner_q[o]] || (grantValid[o] && requestTail[lockOwner_q[o]]))
                    lockValid_d[o] = 1'b0;
            end else if (grantValid[o] && !requestTail[grantIdx[o]]) begin
                lockValid_d[o] = 1'b1;
                lockOwner_d[o] = grantIdx[o];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lockValid_q <= '0;
            for (int o = 0; o < N; o++) lockOwner_q[o] <= '0;
        end else begin
            lockValid_q <= lockValid_d;
            for (int o = 0; o < N; o++) lockOwner_q[o] <= lockOwner_d[o];
        end
    end
`else
    logic unusedTail;
    assign unusedTail = ^requestTail;

    always_comb begin
        ptrHold = '0;
        for (int o = 0; o < N; o++) allowed[o] = '1;
    end
`endif

    always_comb begin
        for (int o = 0; o < N; o++)
            for (int i = 0; i < N; i++)
                reqM[o][i] = outputPortRequest[i][o] & ~holdPorts[o] & ~drop[i] & allowed[o][i];
    end

    // Per-output round-robin search starting at the pointer.
    always_comb begin
        grantValid = '0;
        for (int o = 0; o < N; o++) begin
            grantIdx[o] = '0;
            for (int k = 0; k < N; k++) begin
                if (!grantValid[o] && reqM[o][wrapIdx(ptr_q[o], k)]) begin
                    grantValid[o] = 1'b1;
                    grantIdx[o]   = wrapIdx(ptr_q[o], k);
                end
            end
        end
    end

    always_comb begin
        inputGranted = '0;
        for (int i = 0; i < N; i++)
            for (int o = 0; o < N; o++)
                if (grantValid[o] && (grantIdx[o] == IDX_W'(i))) inputGranted[i] = 1'b1;
    end

    always_comb begin
        for (int o = 0; o < N; o++)
            sel[o] = grantValid[o] ? SEL_W'(grantIdx[o]) : SEL_W'(N);
        writeRequest_Out = grantValid;
        readRequest      = inputGranted | drop;
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            ptr_d[o] = ptr_q[o];
            if (grantValid[o] && !ptrHold[o]) ptr_d[o] = wrapIdx(grantIdx[o], 1);
        end
        for (int i = 0; i < N; i++) begin
            wcnt_d[i] = wcnt_q[i];
            if (!hasReq[i] || inputGranted[i] || drop[i])
                wcnt_d[i] = '0;
            else if (wcnt_q[i] != CNT_W'(DEADLOCK_LIMIT))
                wcnt_d[i] = wcnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < N; o++) ptr_q[o]  <= '0;
            for (int i = 0; i < N; i++) wcnt_q[i] <= '0;
        end else begin
            for (int o = 0; o < N; o++) ptr_q[o]  <= ptr_d[o];
            for (int i = 0; i < N; i++) wcnt_q[i] <= wcnt_d[i];
        end
    end

endmodule

// File: tb/tb_rr_switch_allocator.sv
// tb_rr_switch_allocator: directed self-checking bench for rr_switch_allocator
// (N=5, DEADLOCK_LIMIT=4); expectations follow SA_PACKET_LOCK_EN when defined.
module tb_rr_switch_allocator;

    localparam int N     = 5;
    localparam int LIMIT = 4;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     outputPortRequest [0:N-1];
    logic [N-1:0]     requestTail;
    logic [N-1:0]     holdPorts;
    logic [SEL_W-1:0] sel [0:N-1];
    logic [N-1:0]     readRequest;
    logic [N-1:0]     writeRequest_Out;
    logic [N-1:0]     drop;

    int total = 0;
    int bad   = 0;

`ifdef SA_PACKET_LOCK_EN
    int lockExp [0:3] = '{0, 0, 0, 2};
`else
    int lockExp [0:3] = '{0, 2, 0, 2};
`endif
    int allExp  [0:4] = '{1, 2, 3, 4, 0};

    always #5 clk = ~clk;

    rr_switch_allocator #(.N(N), .DEADLOCK_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .outputPortRequest(outputPortRequest),
        .requestTail      (requestTail),
        .holdPorts        (holdPorts),
        .sel              (sel),
        .readRequest      (readRequest),
        .writeRequest_Out (writeRequest_Out),
        .drop             (drop)
    );

    // Requests must be at most one-hot per input.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            assert ($countones(outputPortRequest[i]) <= 1)
            else $error("[TB] illegal multi-hot request on input %0d", i);
    end

    // Target output per input, -1 meaning no request.
    task automatic applyStimulus(input int t0, input int t1, input int t2, input int t3,
                                 input int t4, input logic [N-1:0] tail,
                                 input logic [N-1:0] hold);
        int t [0:N-1];
        t = '{t0, t1, t2, t3, t4};
        for (int i = 0; i < N; i++)
            outputPortRequest[i] = (t[i] < 0) ? '0 : (N'(1) << t[i]);
        requestTail = tail;
        holdPorts   = hold;
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkSel(input string tag, input int o, input int expected);
        total++;
        assert (sel[o] === SEL_W'(expected)) else begin
            bad++;
            $error("[TB] FAIL %s sel[%0d] observed=%0d expected=%0d", tag, o, sel[o], expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        for (int o = 0; o < N; o++) checkSel(tag, o, N);
        checkOutput(tag, readRequest, '0);
        checkOutput(tag, writeRequest_Out, '0);
        checkOutput(tag, drop, '0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(-1, -1, -1, -1, -1, '1, '0);
        @(negedge clk); #1;
        checkIdle("reset_idle");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkIdle("post_reset_idle");

        $display("[TB] round robin on output 2");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            applyStimulus(-1, 2, -1, 2, -1, '1, '0);
            #1;
            checkSel("rr_sel", 2, (c % 2 == 0) ? 1 : 3);
            checkOutput("rr_read", readRequest, (c % 2 == 0) ? 5'b00010 : 5'b01000);
            checkOutput("rr_write", writeRequest_Out, 5'b00100);
        end

        $display("[TB] hold output 2 for three cycles");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(-1, 2, -1, -1, -1, '1, 5'b00100);
            #1;
            checkSel("hold_sel", 2, N);
            checkOutput("hold_write", writeRequest_Out, '0);
            checkOutput("hold_read", readRequest, '0);
            checkOutput("hold_drop", drop, '0);
        end
        @(negedge clk);
        applyStimulus(-1, 2, -1, 2, -1, '1, '0);
        #1;
        checkSel("release_sel", 2, 3);
        checkOutput("release_read", readRequest, 5'b01000);
        checkOutput("release_drop", drop, '0);
        @(negedge clk);
        applyStimulus(-1, 2, -1, 2, -1, '1, '0);
        #1;
        checkOutput("hold_starve_drop", drop, 5'b00010);
        checkSel("hold_starve_sel", 2, 3);
        checkOutput("hold_starve_read", readRequest, 5'b01010);
        checkOutput("hold_starve_write", writeRequest_Out, 5'b00100);
        @(negedge clk);
        applyStimulus(-1, -1, -1, -1, -1, '1, '0);
        #1;
        checkIdle("idle_1");

        $display("[TB] watchdog on input 0");
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            applyStimulus(4, -1, -1, -1, -1, '1, 5'b10000);
            #1;
            checkOutput("wd_drop", drop, (c == 5 || c == 10) ? 5'b00001 : 5'b00000);
            checkOutput("wd_read", readRequest, (c == 5 || c == 10) ? 5'b00001 : 5'b00000);
            checkOutput("wd_write", writeRequest_Out, '0);
        end
        @(negedge clk);
        applyStimulus(-1, -1, -1, -1, -1, '1, '0);
        #1;
        checkIdle("idle_2");

        $display("[TB] packet from input 0 against input 2 on output 1");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            applyStimulus((c < 3) ? 1 : -1, -1, 1, -1, -1,
                          (c == 2 || c == 3) ? 5'b11111 : 5'b11110, '0);
            #1;
            checkSel("lock_sel", 1, lockExp[c]);
            checkOutput("lock_read", readRequest, N'(1) << lockExp[c]);
            checkOutput("lock_drop", drop, '0);
        end
        @(negedge clk);
        applyStimulus(-1, -1, -1, -1, -1, '1, '0);
        #1;
        checkIdle("idle_3");

        $display("[TB] reset while output 1 busy and input 4 starving");
        @(negedge clk);
        applyStimulus(-1, -1, -1, 1, -1, 5'b10111, '0);
        #1;
        checkSel("pre_rst_sel", 1, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(-1, -1, -1, 1, 3, 5'b10111, 5'b01000);
            #1;
            checkSel("pre_rst_owner", 1, 3);
            checkSel("pre_rst_held", 3, N);
            checkOutput("pre_rst_drop", drop, '0);
        end
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(-1, -1, 1, -1, -1, '1, '0);
        #1;
        checkSel("rst_lock_clear", 1, 2);
        checkOutput("rst_drop", drop, '0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(-1, -1, 1, -1, 1, '1, '0);
        #1;
        checkSel("rst_ptr_zero", 1, 2);
        checkOutput("rst_read", readRequest, 5'b00100);
        @(negedge clk);
        applyStimulus(-1, -1, 1, -1, 1, '1, '0);
        #1;
        checkSel("rst_wcnt_clear", 1, 4);
        checkOutput("rst_wcnt_drop", drop, '0);
        @(negedge clk);
        applyStimulus(-1, -1, -1, -1, -1, '1, '0);
        #1;
        checkIdle("idle_4");

        $display("[TB] all inputs to distinct outputs");
        @(negedge clk);
        applyStimulus(4, 0, 1, 2, 3, '1, '0);
        #1;
        for (int o = 0; o < N; o++) checkSel("all_sel", o, allExp[o]);
        checkOutput("all_read", readRequest, 5'b11111);
        checkOutput("all_write", writeRequest_Out, 5'b11111);
        checkOutput("all_drop", drop, '0);
        @(negedge clk);
        applyStimulus(-1, -1, -1, -1, -1, '1, '0);
        #1;
        checkIdle("idle_5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
